// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard, redirect and HALT-drain sequencer for the 5-stage core.
// Also keeps retired-instruction class counters and a stall-cycle counter.
module ex_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs_add,
  input  logic [4:0]       id_rt_add,
  input  logic             ex_valid,
  input  logic [5:0]       ex_op,
  input  logic [4:0]       ex_rd_add,
  input  logic             ex_branch_taken,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_arith,
  output logic [CNT_W-1:0] cnt_logic,
  output logic [CNT_W-1:0] cnt_mem,
  output logic [CNT_W-1:0] cnt_ctrl,
  output logic [CNT_W-1:0] cnt_stall
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e     state_q, state_d;
  logic [1:0] dcnt_q, dcnt_d;
  logic       halted_q;

  logic [CNT_W-1:0] total_q, arith_q, logic_q;
  logic [CNT_W-1:0] mem_q, ctrl_q, stall_q;

  logic uses_rt, lu, redirect, halt_id;
  logic stall_c, bubble_c, flush_c;
  logic is_ar, is_lg, is_mem, is_ctl;

  assign uses_rt = id_op inside {6'h00, 6'h02, 6'h04, 6'h06,
                                 6'h08, 6'h0A, 6'h0D, 6'h0F};

  assign lu = ex_valid && (ex_op == 6'h0C) &&
              (ex_rd_add != 5'd0) && id_valid &&
              ((id_rs_add == ex_rd_add) ||
               (uses_rt && (id_rt_add == ex_rd_add)));

  assign redirect = ex_valid && ex_branch_taken;
  assign halt_id  = id_valid && (id_op == 6'h11);

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (lu) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (halt_id) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = DRAIN;
          dcnt_d   = 2'd2;
        end
      end
      DRAIN: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (redirect) begin
          flush_c = 1'b1;
          stall_c = 1'b0;
          state_d = RUN;
          dcnt_d  = 2'd0;
        end else if (dcnt_q <= 2'd1) begin
          // last drain cycle: older instructions have left the pipe
          state_d = HALTED;
          dcnt_d  = 2'd0;
        end else begin
          dcnt_d = dcnt_q - 2'd1;
        end
      end
      HALTED: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end
      default: begin
        state_d = RUN;
        dcnt_d  = 2'd0;
      end
    endcase
  end

  assign stall_if_id = reset & stall_c;
  assign bubble_ex   = reset & bubble_c;
  assign flush_if_id = reset & flush_c;

  always_comb begin
    is_ar  = 1'b0;
    is_lg  = 1'b0;
    is_mem = 1'b0;
    is_ctl = 1'b0;
    unique case (1'b1)
      (ex_op <= 6'h05):                   is_ar  = 1'b1;
      (ex_op >= 6'h06 && ex_op <= 6'h0B): is_lg  = 1'b1;
      (ex_op == 6'h0C || ex_op == 6'h0D): is_mem = 1'b1;
      (ex_op >= 6'h0E && ex_op <= 6'h10): is_ctl = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      dcnt_q   <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      halted_q <= (state_d == HALTED);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_q <= '0;
      arith_q <= '0;
      logic_q <= '0;
      mem_q   <= '0;
      ctrl_q  <= '0;
      stall_q <= '0;
    end else begin
      if (ex_valid) begin
        total_q <= total_q + ONE;
        if (is_ar)  arith_q <= arith_q + ONE;
        if (is_lg)  logic_q <= logic_q + ONE;
        if (is_mem) mem_q   <= mem_q + ONE;
        if (is_ctl) ctrl_q  <= ctrl_q + ONE;
      end
      if (stall_c) stall_q <= stall_q + ONE;
    end
  end

  assign halted    = halted_q;
  assign cnt_total = total_q;
  assign cnt_arith = arith_q;
  assign cnt_logic = logic_q;
  assign cnt_mem   = mem_q;
  assign cnt_ctrl  = ctrl_q;
  assign cnt_stall = stall_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: vector table, directed corner sequences,
// and a random run against a cycle-count reference model.
module tb_ex_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, ex_valid, ex_branch_taken;
  logic [5:0] id_op, ex_op;
  logic [4:0] id_rs_add, id_rt_add, ex_rd_add;

  logic stall_if_id, bubble_ex, flush_if_id, halted;
  logic [31:0] c_tot, c_ar, c_lg, c_mem, c_ctl, c_stl;
  logic s_stall, s_bubble, s_flush, s_halted;
  logic [2:0] k_tot, k_ar, k_lg, k_mem, k_ctl, k_stl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_op(id_op),
    .id_rs_add(id_rs_add), .id_rt_add(id_rt_add),
    .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rd_add(ex_rd_add), .ex_branch_taken(ex_branch_taken),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .halted(halted),
    .cnt_total(c_tot), .cnt_arith(c_ar), .cnt_logic(c_lg),
    .cnt_mem(c_mem), .cnt_ctrl(c_ctl), .cnt_stall(c_stl)
  );

  // narrow copy so counter wrap-around is reachable in a short run
  ex_hazard_ctrl #(.CNT_W(3)) u_small (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_op(id_op),
    .id_rs_add(id_rs_add), .id_rt_add(id_rt_add),
    .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rd_add(ex_rd_add), .ex_branch_taken(ex_branch_taken),
    .stall_if_id(s_stall), .bubble_ex(s_bubble),
    .flush_if_id(s_flush), .halted(s_halted),
    .cnt_total(k_tot), .cnt_arith(k_ar), .cnt_logic(k_lg),
    .cnt_mem(k_mem), .cnt_ctrl(k_ctl), .cnt_stall(k_stl)
  );

  typedef struct {
    logic       idv;
    logic [5:0] iop;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       exv;
    logic [5:0] eop;
    logic [4:0] rd;
    logic       bt;
    logic       s;
    logic       b;
    logic       f;
  } vec_t;

  vec_t tbl[14];

  // model: k = cycles since HALT accepted (0 = running, 3+ = halted)
  int k;
  longint unsigned m[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic idv, input logic [5:0] iop,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic exv, input logic [5:0] eop,
                       input logic [4:0] rd, input logic bt);
    id_valid = idv; id_op = iop; id_rs_add = rs; id_rt_add = rt;
    ex_valid = exv; ex_op = eop; ex_rd_add = rd; ex_branch_taken = bt;
  endtask

  task automatic idle();
    drive(1'b0, 6'h3F, 5'd0, 5'd0, 1'b0, 6'h3F, 5'd0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic s,
                         input logic b, input logic f);
    chk({nm, "_sbf"}, {61'd0, stall_if_id, bubble_ex, flush_if_id},
        {61'd0, s, b, f});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    @(negedge clk);
    reset = 1'b1;
    cyc();
    k = 0;
    for (int i = 0; i < 6; i++) m[i] = 0;
  endtask

  function automatic int cls(input logic [5:0] op);
    if (op <= 6'h05) return 1;
    if (op <= 6'h0B) return 2;
    if (op <= 6'h0D) return 3;
    if (op <= 6'h10) return 4;
    return 0;
  endfunction

  task automatic model_out(output logic s, output logic b,
                           output logic f);
    logic rt_used, hz, rdr, hlt;
    rt_used = 1'b0;
    foreach (id_op[i]) ;
    case (id_op)
      6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A, 6'h0D, 6'h0F:
        rt_used = 1'b1;
      default: rt_used = 1'b0;
    endcase
    hz = ex_valid && ex_op == 6'h0C && ex_rd_add != 0 && id_valid &&
         (id_rs_add == ex_rd_add || (rt_used && id_rt_add == ex_rd_add));
    rdr = ex_valid && ex_branch_taken;
    hlt = id_valid && id_op == 6'h11;
    s = 0; b = 0; f = 0;
    if (k >= 3) begin
      s = 1; b = 1;
    end else if (k >= 1) begin
      b = 1;
      s = !rdr;
      f = rdr;
    end else if (rdr) begin
      f = 1; b = 1;
    end else if (hz || hlt) begin
      s = 1; b = 1;
    end
  endtask

  task automatic model_edge(input logic s);
    logic rdr, hlt, hz_s, hz_b, hz_f;
    rdr = ex_valid && ex_branch_taken;
    hlt = id_valid && id_op == 6'h11;
    model_out(hz_s, hz_b, hz_f);
    if (k == 0) begin
      // a HALT that is not stalled by a load-use starts the drain
      if (!rdr && hlt && hz_s) begin
        logic lu_only;
        lu_only = ex_valid && ex_op == 6'h0C && ex_rd_add != 0 &&
                  (id_rs_add == ex_rd_add);
        if (!lu_only) k = 1;
      end
    end else if (k < 3) begin
      k = rdr ? 0 : k + 1;
    end
    if (ex_valid) begin
      m[0]++;
      if (cls(ex_op) != 0) m[cls(ex_op)]++;
    end
    if (s) m[5]++;
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, "_total"}, {32'd0, c_tot}, m[0] & 64'hFFFF_FFFF);
    chk({nm, "_arith"}, {32'd0, c_ar}, m[1] & 64'hFFFF_FFFF);
    chk({nm, "_logic"}, {32'd0, c_lg}, m[2] & 64'hFFFF_FFFF);
    chk({nm, "_mem"}, {32'd0, c_mem}, m[3] & 64'hFFFF_FFFF);
    chk({nm, "_ctrl"}, {32'd0, c_ctl}, m[4] & 64'hFFFF_FFFF);
    chk({nm, "_stall"}, {32'd0, c_stl}, m[5] & 64'hFFFF_FFFF);
    chk({nm, "_w3"}, {46'd0, k_tot, k_ar, k_lg, k_mem, k_ctl, k_stl},
        {46'd0, 3'(m[0]), 3'(m[1]), 3'(m[2]),
         3'(m[3]), 3'(m[4]), 3'(m[5])});
  endtask

  initial begin
    logic es, eb, ef;
    int hcnt;
    reset = 1'b0;
    idle();
    k = 0;
    for (int i = 0; i < 6; i++) m[i] = 0;

    tbl[0]  = '{1, 6'h00, 5'd3, 5'd0, 1, 6'h0C, 5'd3, 0, 1, 1, 0};
    tbl[1]  = '{1, 6'h00, 5'd0, 5'd0, 1, 6'h0C, 5'd0, 0, 0, 0, 0};
    tbl[2]  = '{1, 6'h07, 5'd1, 5'd5, 1, 6'h0C, 5'd5, 0, 0, 0, 0};
    tbl[3]  = '{1, 6'h06, 5'd1, 5'd5, 1, 6'h0C, 5'd5, 0, 1, 1, 0};
    tbl[4]  = '{1, 6'h0D, 5'd1, 5'd5, 1, 6'h0C, 5'd5, 0, 1, 1, 0};
    tbl[5]  = '{1, 6'h00, 5'd3, 5'd0, 1, 6'h00, 5'd3, 0, 0, 0, 0};
    tbl[6]  = '{1, 6'h00, 5'd3, 5'd0, 0, 6'h0C, 5'd3, 0, 0, 0, 0};
    tbl[7]  = '{0, 6'h00, 5'd3, 5'd0, 1, 6'h0C, 5'd3, 0, 0, 0, 0};
    tbl[8]  = '{1, 6'h00, 5'd3, 5'd0, 1, 6'h0F, 5'd3, 1, 0, 1, 1};
    tbl[9]  = '{1, 6'h11, 5'd0, 5'd0, 0, 6'h00, 5'd0, 0, 1, 1, 0};
    tbl[10] = '{1, 6'h11, 5'd0, 5'd0, 1, 6'h10, 5'd0, 1, 0, 1, 1};
    tbl[11] = '{1, 6'h3F, 5'd0, 5'd0, 0, 6'h0E, 5'd0, 1, 0, 0, 0};
    tbl[12] = '{1, 6'h0F, 5'd1, 5'd7, 1, 6'h0C, 5'd7, 0, 1, 1, 0};
    tbl[13] = '{1, 6'h10, 5'd1, 5'd7, 1, 6'h0C, 5'd7, 0, 0, 0, 0};

    // reset state, with hazard-inducing inputs applied
    drive(1, 6'h11, 5'd3, 5'd3, 1, 6'h0C, 5'd3, 1);
    cyc();
    cyc();
    chk_out("rst_force", 0, 0, 0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk_cnts("rst");
    idle();
    @(negedge clk);
    reset = 1'b1;

    // combinational table, applied between edges in RUN
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].idv, tbl[i].iop, tbl[i].rs, tbl[i].rt,
            tbl[i].exv, tbl[i].eop, tbl[i].rd, tbl[i].bt);
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].s, tbl[i].b, tbl[i].f);
      idle();
    end
    #1;
    chk_cnts("vec_end");

    // load-use: one stall then released
    do_reset();
    drive(1, 6'h00, 5'd3, 5'd1, 1, 6'h0C, 5'd3, 0);
    #1;
    chk_out("lu_c0", 1, 1, 0);
    cyc();
    drive(1, 6'h00, 5'd3, 5'd1, 0, 6'h3F, 5'd0, 0);
    #1;
    chk_out("lu_c1", 0, 0, 0);
    chk("lu_stall", {32'd0, c_stl}, 64'd1);
    chk("lu_mem", {32'd0, c_mem}, 64'd1);

    // taken BEQ with dependent op in ID
    do_reset();
    drive(1, 6'h00, 5'd3, 5'd3, 1, 6'h0F, 5'd3, 1);
    #1;
    chk_out("beq", 0, 1, 1);
    cyc();
    idle();
    #1;
    chk_out("beq_after", 0, 0, 0);
    chk("beq_ctrl", {32'd0, c_ctl}, 64'd1);
    chk("beq_stall", {32'd0, c_stl}, 64'd0);

    // HALT drain, then async reset out of HALTED
    do_reset();
    drive(1, 6'h11, 5'd0, 5'd0, 0, 6'h3F, 5'd0, 0);
    #1;
    chk_out("halt_T", 1, 1, 0);
    for (int t = 1; t <= 8; t++) begin
      cyc();
      chk_out($sformatf("halt_T%0d", t), 1, 1, 0);
      chk($sformatf("halt_h_T%0d", t), {63'd0, halted},
          {63'd0, t >= 3});
      chk($sformatf("halt_st_T%0d", t), {32'd0, c_stl}, 64'(t));
    end
    #1;
    reset = 1'b0;
    #1;
    chk("arst_halted", {63'd0, halted}, 64'd0);
    chk("arst_stall", {32'd0, c_stl}, 64'd0);
    chk_out("arst_out", 0, 0, 0);
    reset = 1'b1;
    idle();
    cyc();
    chk("arst_run", {63'd0, halted}, 64'd0);

    // HALT cancelled by BZ taken in the first drain cycle
    do_reset();
    drive(1, 6'h11, 5'd0, 5'd0, 0, 6'h3F, 5'd0, 0);
    cyc();
    drive(1, 6'h11, 5'd0, 5'd0, 1, 6'h0E, 5'd0, 1);
    #1;
    chk_out("hbz_d1", 0, 1, 1);
    cyc();
    idle();
    #1;
    chk_out("hbz_run", 0, 0, 0);
    cyc();
    cyc();
    chk("hbz_halted", {63'd0, halted}, 64'd0);
    chk("hbz_ctrl", {32'd0, c_ctl}, 64'd1);

    // counter wrap on the narrow instance
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(0, 6'h3F, 5'd0, 5'd0, 1, 6'h3F, 5'd0, 0);
      cyc();
    end
    chk("wrap_pre", {61'd0, k_tot}, 64'd7);
    drive(0, 6'h3F, 5'd0, 5'd0, 1, 6'h00, 5'd0, 0);
    cyc();
    idle();
    chk("wrap_tot", {61'd0, k_tot}, 64'd0);
    chk("wrap_ar", {61'd0, k_ar}, 64'd1);
    chk("wrap_big", {32'd0, c_tot}, 64'd8);

    // random run against the model
    do_reset();
    hcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] eo, io;
      eo = ($urandom_range(0, 9) < 4) ? 6'h0C : 6'($urandom_range(0, 19));
      io = ($urandom_range(0, 29) == 0) ? 6'h11
         : 6'($urandom_range(0, 19));
      drive($urandom_range(0, 3) != 0, io,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, eo, 5'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0);
      #1;
      model_out(es, eb, ef);
      chk("rnd_out", {61'd0, stall_if_id, bubble_ex, flush_if_id},
          {61'd0, es, eb, ef});
      model_edge(es);
      cyc();
      chk("rnd_halted", {63'd0, halted}, {63'd0, k >= 3});
      chk_cnts("rnd");
      hcnt = (k >= 3) ? hcnt + 1 : 0;
      if (hcnt > 4) begin
        reset = 1'b0;
        #1;
        k = 0;
        for (int i = 0; i < 6; i++) m[i] = 0;
        chk("rnd_arst", {63'd0, halted}, 64'd0);
        chk_cnts("rnd_arst");
        reset = 1'b1;
        hcnt = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
